// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - execute-stage ALU with iterative shift-add multiply and restoring divide
module alu_muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_FLAG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULH  = 4'b1001;
  localparam logic [3:0] OP_HOLE  = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, bm, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg, sign_diff;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   alu_res, fix_res;
  logic               op_signed, a_sgn, b_sgn;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic               div0, ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  assign op_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_sgn     = op_signed & a[WIDTH-1];
  assign b_sgn     = op_signed & b[WIDTH-1];

  // Multiplier sits in the low half of prod and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + ({1'b0, bm} & {(WIDTH+1){prod[0]}});
  // rem < bm always holds for a nonzero divisor, so bit WIDTH of the difference is the borrow.
  assign div_sh   = {rem, quo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, bm};

  assign prod_fix = sign_diff ? -prod : prod;
  assign div0     = (b_q == '0);
  assign ovf      = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:   fix_res = prod_fix[WIDTH-1:0];
      OP_MULH:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:   fix_res = div0 ? '1 : (ovf ? a_q : (sign_diff ? -quo : quo));
      OP_DIVU:  fix_res = div0 ? '1 : quo;
      OP_REM:   fix_res = div0 ? a_q : (ovf ? '0 : (a_neg ? -rem : rem));
      OP_REMU:  fix_res = div0 ? a_q : rem;
      default:  fix_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      zero      <= ZERO_FLAG;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      bm        <= '0;
      quo       <= '0;
      rem       <= '0;
      prod      <= '0;
      a_neg     <= 1'b0;
      sign_diff <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q      <= op;
            a_q       <= a;
            b_q       <= b;
            bm        <= mag(b, b_sgn);
            a_neg     <= a_sgn;
            sign_diff <= a_sgn ^ b_sgn;
            cnt       <= '0;
            if (!op[3] || op == OP_HOLE) begin
              result <= alu_res;
              zero   <= ZERO_FLAG && (alu_res == '0);
              done   <= 1'b1;
            end else if (!op[2]) begin
              prod  <= {{WIDTH{1'b0}}, mag(a, a_sgn)};
              busy  <= 1'b1;
              state <= S_MUL;
            end else begin
              quo   <= mag(a, a_sgn);
              rem   <= '0;
              busy  <= 1'b1;
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= S_FIX;
        end
        S_DIV: begin
          if (!div_diff[WIDTH]) begin
            rem <= div_diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          zero   <= ZERO_FLAG && (fix_res == '0);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq at WIDTH=32 and WIDTH=8
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, start8;
  logic [3:0]  op, op8;
  logic [31:0] a, b, result;
  logic [7:0]  a8, b8, result8;
  logic        busy, done, zero, busy8, done8, zero8;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(32), .ZERO_FLAG(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  alu_muldiv_seq #(.WIDTH(8), .ZERO_FLAG(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .zero(zero8)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  o;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] exp;
    int          lat;
    bit          w8;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign-extended / masked operands.
  function automatic logic [63:0] model(input int w, input logic [3:0] o,
                                        input logic [63:0] x, input logic [63:0] y);
    longint unsigned mask, ux, uy;
    longint          sx, sy, minv, p;
    logic [63:0]     r;
    mask = (longint'(1) << w) - 1;
    ux   = x & mask;
    uy   = y & mask;
    sx   = ux[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy   = uy[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    minv = -(longint'(1) << (w-1));
    r    = '0;
    case (o)
      4'd0:  r = ux & uy;
      4'd1:  r = ux | uy;
      4'd2:  r = (ux + uy) & mask;
      4'd6:  r = (ux - uy) & mask;
      4'd7:  r = (sx < sy) ? 64'd1 : 64'd0;
      4'd8:  r = (ux * uy) & mask;
      4'd9:  begin p = sx * sy; r = (p >>> w) & mask; end
      4'd11: r = ((ux * uy) >> w) & mask;
      4'd12: begin
        if (uy == 0) r = mask;
        else if (sx == minv && sy == -1) r = ux;
        else begin p = sx / sy; r = p & mask; end
      end
      4'd13: r = (uy == 0) ? mask : ux / uy;
      4'd14: begin
        if (uy == 0) r = ux;
        else if (sx == minv && sy == -1) r = 0;
        else begin p = sx % sy; r = p & mask; end
      end
      4'd15: r = (uy == 0) ? ux : ux % uy;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask, v;
    mask = (64'd1 << w) - 1;
    case ($urandom_range(0, 7))
      0: v = 0;
      1: v = mask;
      2: v = 64'd1 << (w - 1);
      3: v = 1;
      default: v = {$urandom, $urandom} & mask;
    endcase
    return v;
  endfunction

  // Called with the DUT idle (or in its done cycle); returns in the done cycle.
  task automatic run(input bit w8, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                     output logic [63:0] res, output logic z, output int lat, output int bcnt);
    if (w8) begin start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; end
    else    begin start  = 1'b1; op  = o; a  = x[31:0]; b = y[31:0]; end
    @(posedge clk); #1;
    start = 1'b0; start8 = 1'b0;
    lat  = 1;
    bcnt = (w8 ? busy8 : busy) ? 1 : 0;
    while (!(w8 ? done8 : done) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (w8 ? busy8 : busy) bcnt++;
    end
    res = w8 ? {56'b0, result8} : {32'b0, result};
    z   = w8 ? zero8 : zero;
  endtask

  initial begin
    logic [63:0] res, exp, x, y;
    logic [3:0]  o;
    logic        z, seen;
    int          lat, bcnt, elat;
    bit          iter;

    tbl.push_back('{4'b0010, 64'hffffffff, 64'h1,        64'h0,        1,  1'b0});
    tbl.push_back('{4'b0111, 64'hffffffff, 64'h1,        64'h1,        1,  1'b0});
    tbl.push_back('{4'b0110, 64'h5,        64'h7,        64'hfffffffe, 1,  1'b0});
    tbl.push_back('{4'b0000, 64'hf0f0ff00, 64'h0ff0f0f0, 64'h00f0f000, 1,  1'b0});
    tbl.push_back('{4'b0001, 64'hf0f00000, 64'h0000000f, 64'hf0f0000f, 1,  1'b0});
    tbl.push_back('{4'b1010, 64'h12345678, 64'h9,        64'h0,        1,  1'b0});
    tbl.push_back('{4'b1000, 64'h00010000, 64'h00010000, 64'h0,        34, 1'b0});
    tbl.push_back('{4'b1001, 64'hfffffffe, 64'h3,        64'hffffffff, 34, 1'b0});
    tbl.push_back('{4'b1011, 64'hffffffff, 64'hffffffff, 64'hfffffffe, 34, 1'b0});
    tbl.push_back('{4'b1100, 64'hfffffff9, 64'h2,        64'hfffffffd, 34, 1'b0});
    tbl.push_back('{4'b1110, 64'hfffffff9, 64'h2,        64'hffffffff, 34, 1'b0});
    tbl.push_back('{4'b1101, 64'h7,        64'h0,        64'hffffffff, 34, 1'b0});
    tbl.push_back('{4'b1111, 64'h7,        64'h0,        64'h7,        34, 1'b0});
    tbl.push_back('{4'b1100, 64'h80000000, 64'hffffffff, 64'h80000000, 34, 1'b0});
    tbl.push_back('{4'b1110, 64'h80000000, 64'hffffffff, 64'h0,        34, 1'b0});
    tbl.push_back('{4'b1100, 64'h80,       64'hff,       64'h80,       10, 1'b1});
    tbl.push_back('{4'b0010, 64'hff,       64'h1,        64'h0,        1,  1'b1});
    tbl.push_back('{4'b1011, 64'hff,       64'hff,       64'hfe,       10, 1'b1});

    // Reset with start held high: nothing may be accepted.
    rst_n = 1'b0;
    start = 1'b1;  op  = 4'b0010; a  = 32'd1; b  = 32'd2;
    start8 = 1'b1; op8 = 4'b0010; a8 = 8'd1;  b8 = 8'd2;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset result", {32'b0, result}, 64'd0);
    check("reset zero", {63'b0, zero}, 64'd1);
    check("reset zero8 (flag off)", {63'b0, zero8}, 64'd0);
    check("reset busy8", {63'b0, busy8}, 64'd0);
    rst_n = 1'b1; start = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    check("post-reset done", {63'b0, done}, 64'd0);

    foreach (tbl[i]) begin
      run(tbl[i].w8, tbl[i].o, tbl[i].x, tbl[i].y, res, z, lat, bcnt);
      check($sformatf("vec%0d result", i), res, tbl[i].exp);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("vec%0d busy cycles", i), 64'(bcnt), 64'(tbl[i].lat - 1));
      check($sformatf("vec%0d zero", i), {63'b0, z},
            (!tbl[i].w8 && tbl[i].exp == 0) ? 64'd1 : 64'd0);
    end

    // start while busy is ignored.
    start = 1'b1; op = 4'b1101; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin start = 1'b1; op = 4'b0010; a = 32'd2; b = 32'd3; end
      else start = 1'b0;
    end
    check("busy-ignore latency", 64'(lat), 64'd34);
    check("busy-ignore result", {32'b0, result}, 64'd14);

    // start in the done cycle is accepted.
    start = 1'b1; op = 4'b0010; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b done", {63'b0, done}, 64'd1);
    check("b2b result", {32'b0, result}, 64'd5);
    @(posedge clk); #1;
    check("done single pulse", {63'b0, done}, 64'd0);
    check("result held", {32'b0, result}, 64'd5);

    // Reset mid-multiply aborts without a done.
    start = 1'b1; op = 4'b1000; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort busy", {63'b0, busy}, 64'd0);
    check("abort done", {63'b0, done}, 64'd0);
    check("abort result", {32'b0, result}, 64'd0);
    check("abort zero", {63'b0, zero}, 64'd1);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check("abort no done", {63'b0, seen}, 64'd0);

    for (int i = 0; i < 160; i++) begin
      o = 4'($urandom_range(0, 15));
      x = pick(32);
      y = pick(32);
      iter = o[3] && (o != 4'b1010);
      elat = iter ? 34 : 1;
      exp = model(32, o, x, y);
      run(1'b0, o, x, y, res, z, lat, bcnt);
      check($sformatf("rnd32 op%0h %0h,%0h result", o, x, y), res, exp);
      check($sformatf("rnd32 op%0h latency", o), 64'(lat), 64'(elat));
      check($sformatf("rnd32 op%0h zero", o), {63'b0, z}, (exp == 0) ? 64'd1 : 64'd0);
    end

    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = pick(8);
      y = pick(8);
      iter = o[3] && (o != 4'b1010);
      elat = iter ? 10 : 1;
      exp = model(8, o, x, y);
      run(1'b1, o, x, y, res, z, lat, bcnt);
      check($sformatf("rnd8 op%0h %0h,%0h result", o, x, y), res, exp);
      check($sformatf("rnd8 op%0h latency", o), 64'(lat), 64'(elat));
      check($sformatf("rnd8 op%0h zero", o), {63'b0, z}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Parametrised successor to the single-cycle datapath ALU. It keeps the existing logic and arithmetic op codes and adds RV32M-style multiply, divide and remainder operations. Multiply and divide run as iterative multi-cycle units. The block sits in the execute stage behind a start/busy/done handshake, so the control unit can stall the PC while a long operation completes. All outputs are registered.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 8..64.
- ZERO_FLAG, 1, when 1 the zero output is driven; when 0 zero is tied to 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  request; sampled only when busy=0.
- op  in  4  operation select; encoding given under Behaviour.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- busy  out  1  high while an iterative operation is in progress.
- done  out  1  one-cycle pulse; result and zero are valid in that cycle.
- result  out  WIDTH  registered result; held until the next done.
- zero  out  1  registered (result==0), updated together with result.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - busy=0, done=0, result=0, zero=1 (0 if ZERO_FLAG=0).
  - FSM returns to IDLE.
  - Reset during a multi-cycle op aborts it; no done is produced.
- Op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0).
  - 1000 MUL (low WIDTH bits), 1001 MULH (signed x signed, high WIDTH), 1011 MULHU (unsigned x unsigned, high WIDTH).
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
  - All other codes: result=0, single-cycle.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH.
  - Signed ops use two's complement.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - Accept when start=1. Operands and op are latched at the accepting edge.
  - Single-cycle op: result registered at the accepting edge; done=1 in the following cycle; busy stays 0; FSM stays in IDLE.
  - MUL* op: operand magnitudes and signs latched; busy=1; go to MUL.
  - DIV/REM op: operand magnitudes and signs latched; busy=1; go to DIV.
- MUL: shift-add, one bit per cycle, exactly WIDTH cycles, into a 2*WIDTH product; then go to FIX.
- DIV: restoring divide, one quotient bit per cycle, exactly WIDTH cycles; then go to FIX.
- FIX (one cycle):
  - Apply sign correction:
    - MULH: negate the product when the operand signs differ.
    - Quotient: negate when the operand signs differ.
    - Remainder: takes the sign of the dividend.
  - Register result and zero; done=1 in the next cycle; busy=0; return to IDLE.
- Latency, counted from the accepting edge to the cycle where done=1:
  - Single-cycle ops: 1 cycle.
  - Iterative ops: WIDTH+2 cycles (34 for WIDTH=32).
  - Latency is fixed and does not depend on the data.
- Special cases, resolved in FIX:
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = a.
  - Signed overflow (a = most-negative value, b = -1): DIV returns a; REM returns 0.
- Handshake rules:
  - start while busy=1 is ignored; the in-flight op is unaffected.
  - start in the same cycle as done=1 is accepted, allowing back-to-back issue.
  - done is never high for two consecutive cycles for the same op.
- result and zero change only on the edge that precedes done=1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, result=0, zero=1; nothing is accepted.
- Single-cycle ops, WIDTH=32:
  - ADD 0xFFFFFFFF+1 -> done at +1, result=0, zero=1.
  - SLT -1 vs 1 -> result=1.
  - SUB 5-7 -> result=0xFFFFFFFE.
- Multiply:
  - MUL 0x00010000 x 0x00010000 -> result=0, done at +34, busy high for cycles +1..+33.
  - MULH -2 x 3 -> result=0xFFFFFFFF.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE.
- Divide:
  - DIV -7/2 -> -3 (0xFFFFFFFD).
  - REM -7/2 -> -1.
  - DIVU 7/0 -> 0xFFFFFFFF.
  - REMU 7/0 -> 7.
  - DIV 0x80000000 / -1 -> 0x80000000.
  - REM 0x80000000 / -1 -> 0.
- Handshake:
  - Start DIVU 100/7; pulse start with ADD at +5 -> ignored; done at +34, result=14.
  - Start ADD 2+3 in the done cycle -> accepted; done next cycle, result=5.
- Abort and parametrisation:
  - Assert rst_n=0 at cycle +10 of a MUL -> no done; outputs at reset values.
  - WIDTH=8: DIV -128/-1 -> result 0x80, done at +10.
